muldiv_sequencer: RTL and testbench

- Iterative multiply/divide sequencer for the MIPS datapath. It owns the HI/LO register pair and executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Sits beside the ALU in EX. The control path issues a request with the funct field, and the block runs a shift-add or restoring-divide loop over many cycles.
- The block raises oStall when the pipeline must hold.
- mfhi/mflo results are muxed into the EX result path by the surrounding datapath.

---
 rtl/muldiv_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative multiply/divide unit for the MIPS EX stage. It owns the HI/LO
// register pair and executes mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
// Multiplies use a shift-add loop. Divides use a restoring loop. Either loop
// runs one iteration per cycle. A final FIX cycle applies the result signs.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous reset, active-low
//   iStart   request valid from EX
//   iFunc    MIPS funct field (16..19, 24..27 recognised, others ignored)
//   iRs/iRt  operands (rs: multiplicand/dividend/mthi-mtlo source,
//            rt: multiplier/divisor)
//   iFlush   squash the in-flight operation, or a same-cycle request
//   oStall   EX must hold its request this cycle
//   oBusy    loop in progress (CALC or FIX)
//   oDone    one-cycle pulse: HI/LO hold a new mult/div result
//   oHI/oLO  HI and LO registers
//   oResult  mfhi/mflo read data (combinational, 0 for other funcs)
//
// Optional build macro: MULDIV_EARLY_TERM_EN. When it is defined, a
// multiply leaves CALC as soon as the remaining multiplier bits are all
// zero. The result does not change. Division always runs the full loop.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic [5:0]        iFunc,
  input  logic [DATA_W-1:0] iRs,
  input  logic [DATA_W-1:0] iRt,
  input  logic              iFlush,
  output logic              oStall,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oHI,
  output logic [DATA_W-1:0] oLO,
  output logic [DATA_W-1:0] oResult
);

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_reg, state_next;
  logic [DATA_W-1:0]     hi_reg, lo_reg;
  logic [CNT_W-1:0]      cnt_reg;
  // Multiply: acc_reg is the 2W-bit product accumulator.
  // Divide:   acc_reg upper half holds the remainder. The lower half holds
  //           the dividend, which shifts out as quotient bits shift in.
  logic [2*DATA_W-1:0]   acc_reg;
  // Multiply: the multiplicand, shifted left once per iteration.
  // Divide:   the divisor, kept in the lower half.
  logic [2*DATA_W-1:0]   mcand_reg;
  logic [DATA_W-1:0]     mplier_reg;
  logic                  is_mul_reg;
  logic                  neg_q_reg;   // product sign, or quotient sign
  logic                  neg_r_reg;   // remainder sign (the sign of rs)

  // ---------------- request decode ----------------
  logic is_op_mul, is_op_div, is_signed, valid_func;
  logic idle_like, accept, div_zero;
  logic rs_neg, rt_neg;
  logic [DATA_W-1:0] rs_mag, rt_mag;

  always_comb begin
    is_op_mul  = (iFunc == F_MULT) || (iFunc == F_MULTU);
    is_op_div  = (iFunc == F_DIV)  || (iFunc == F_DIVU);
    is_signed  = (iFunc == F_MULT) || (iFunc == F_DIV);
    valid_func = is_op_mul || is_op_div ||
                 (iFunc == F_MFHI) || (iFunc == F_MTHI) ||
                 (iFunc == F_MFLO) || (iFunc == F_MTLO);
    idle_like  = (state_reg == IDLE) || (state_reg == DONE);
    accept     = idle_like && iStart && !iFlush;
    div_zero   = is_op_div && (iRt == '0);
    rs_neg     = is_signed && iRs[DATA_W-1];
    rt_neg     = is_signed && iRt[DATA_W-1];
    rs_mag     = rs_neg ? -iRs : iRs;
    rt_mag     = rt_neg ? -iRt : iRt;
  end

  // ---------------- one loop iteration ----------------
  logic [2*DATA_W-1:0] mul_acc;
  logic [DATA_W:0]     rem_sh, rem_diff;
  logic                rem_fits;
  logic [2*DATA_W-1:0] div_acc;

  always_comb begin
    mul_acc  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    // Shift the next dividend bit into the remainder, then try a subtract.
    // The remainder is always below the divisor, so bit DATA_W of the
    // difference is set exactly when the subtract would go negative.
    rem_sh   = {acc_reg[2*DATA_W-1:DATA_W], acc_reg[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, mcand_reg[DATA_W-1:0]};
    rem_fits = !rem_diff[DATA_W];
    div_acc  = {(rem_fits ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0]),
                acc_reg[DATA_W-2:0], rem_fits};
  end

  // ---------------- sign fix-up ----------------
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quot_fix = neg_q_reg ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0];
    rem_fix  = neg_r_reg ? -acc_reg[2*DATA_W-1:DATA_W]
                         : acc_reg[2*DATA_W-1:DATA_W];
  end

  // ---------------- next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept && (is_op_mul || is_op_div))
          state_next = div_zero ? DONE : CALC;
      end
      CALC: begin
        if (iFlush)
          state_next = IDLE;
        else if (cnt_reg == LAST_ITER)
          state_next = FIX;
`ifdef MULDIV_EARLY_TERM_EN
        // This iteration consumes mplier_reg[0]. No set bits remain above
        // it, so later iterations would add nothing.
        else if (is_mul_reg && (mplier_reg[DATA_W-1:1] == '0))
          state_next = FIX;
`endif
      end
      FIX:     state_next = iFlush ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      is_mul_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (iFunc == F_MTHI) begin
              hi_reg <= iRs;
            end else if (iFunc == F_MTLO) begin
              lo_reg <= iRs;
            end else if (is_op_mul || is_op_div) begin
              if (div_zero) begin
                hi_reg <= iRs;
                lo_reg <= '1;
              end else begin
                cnt_reg    <= '0;
                is_mul_reg <= is_op_mul;
                neg_q_reg  <= rs_neg ^ rt_neg;
                neg_r_reg  <= rs_neg;
                mplier_reg <= rt_mag;
                if (is_op_mul) begin
                  acc_reg   <= '0;
                  mcand_reg <= {{DATA_W{1'b0}}, rs_mag};
                end else begin
                  acc_reg   <= {{DATA_W{1'b0}}, rs_mag};
                  mcand_reg <= {{DATA_W{1'b0}}, rt_mag};
                end
              end
            end
          end
        end
        CALC: begin
          if (!iFlush) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (is_mul_reg) begin
              acc_reg    <= mul_acc;
              mcand_reg  <= mcand_reg << 1;
              mplier_reg <= mplier_reg >> 1;
            end else begin
              acc_reg <= div_acc;
            end
          end
        end
        FIX: begin
          if (!iFlush) begin
            if (is_mul_reg) begin
              hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
              lo_reg <= prod_fix[DATA_W-1:0];
            end else begin
              hi_reg <= rem_fix;
              lo_reg <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    oBusy   = (state_reg == CALC) || (state_reg == FIX);
    // A busy unit stalls every recognised request. An unrecognised funct is
    // ignored, so it never holds the pipeline.
    oStall  = oBusy && iStart && valid_func;
    oDone   = (state_reg == DONE);
    oHI     = hi_reg;
    oLO     = lo_reg;
    oResult = '0;
    if (iFunc == F_MFHI)      oResult = hi_reg;
    else if (iFunc == F_MFLO) oResult = lo_reg;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iStart = 1'b0;
  logic [5:0]  iFunc = 6'd0;
  logic [31:0] iRs = '0;
  logic [31:0] iRt = '0;
  logic        iFlush = 1'b0;
  logic        oStall, oBusy, oDone;
  logic [31:0] oHI, oLO, oResult;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .iFunc(iFunc),
    .iRs(iRs), .iRt(iRt), .iFlush(iFlush), .oStall(oStall),
    .oBusy(oBusy), .oDone(oDone), .oHI(oHI), .oLO(oLO), .oResult(oResult)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [31:0] hi; logic [31:0] lo; } hilo_t;
  hilo_t       done_q[$];
  logic [31:0] res_q[$];

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_muldiv(input logic [5:0] f);
    return (f >= 6'd24) && (f <= 6'd27);
  endfunction

  // Reference model: plain arithmetic on the architectural HI/LO values.
  function automatic void model_apply(input logic [5:0] f, input logic [31:0] rs,
                                      input logic [31:0] rt);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    case (f)
      6'd24: begin p = sa * sb; model_hi = p[63:32]; model_lo = p[31:0]; end
      6'd25: begin p = {32'b0, rs} * {32'b0, rt}; model_hi = p[63:32]; model_lo = p[31:0]; end
      6'd26, 6'd27: begin
        if (rt == 0) begin
          model_hi = rs; model_lo = 32'hFFFF_FFFF;
        end else if (f == 6'd26) begin
          q = sa / sb; r = sa % sb;
          model_lo = q[31:0]; model_hi = r[31:0];
        end else begin
          model_lo = rs / rt; model_hi = rs % rt;
        end
      end
      6'd17: model_hi = rs;
      6'd19: model_lo = rs;
      default: ;
    endcase
  endfunction

  // Hold the request until the DUT accepts it. Unless discard is set,
  // update the model and push the expectations the monitor will need.
  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input bit discard, output int acc_cyc);
    int n;
    @(negedge clk);
    iStart = 1'b1; iFunc = f; iRs = rs; iRt = rt;
    #1;
    for (n = 0; n < 200 && oStall; n++) begin
      @(negedge clk);
      #1;
    end
    if (oStall) begin
      $display("FAIL accept_timeout func=%0d", f);
      failures++;
      $fatal(1, "request never accepted");
    end
    if (!discard) begin
      if (f == 6'd16) res_q.push_back(model_hi);
      if (f == 6'd18) res_q.push_back(model_lo);
      model_apply(f, rs, rt);
      if (is_muldiv(f)) done_q.push_back('{hi: model_hi, lo: model_lo});
    end
    $display("issue func=%0d rs=%h rt=%h cycle=%0d", f, rs, rt, cyc);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    iStart = 1'b0;
  endtask

  // Wait for oDone and check the latency and the number of busy cycles.
  // exp_busy < 0 skips the busy count.
  task automatic wait_done(input int c0, input int exp_lat, input int exp_busy);
    int busy = 0;
    bit seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (oDone) begin seen = 1; break; end
      if (oBusy) busy++;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
`ifdef MULDIV_EARLY_TERM_EN
      if (exp_lat == 34) chk("latency_le_34", 64'(cyc - c0 + 1 <= 34), 64'd1);
      else chk("latency", 64'(cyc - c0 + 1), 64'(exp_lat));
`else
      chk("latency", 64'(cyc - c0 + 1), 64'(exp_lat));
`endif
      if (exp_busy >= 0) chk("busy_cycles", 64'(busy), 64'(exp_busy));
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    int c0;
    issue(f, rs, rt, 0, c0);
    if (is_muldiv(f)) begin
      if ((f == 6'd26 || f == 6'd27) && rt == 0) wait_done(c0, 1, 0);
      else begin
`ifdef MULDIV_EARLY_TERM_EN
        wait_done(c0, 34, (f <= 6'd25) ? -1 : 33);
`else
        wait_done(c0, 34, 33);
`endif
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    hilo_t e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (oDone) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = done_q.pop_front();
            chk("done_hi", 64'(oHI), 64'(e.hi));
            chk("done_lo", 64'(oLO), 64'(e.lo));
            $display("done hi=%h lo=%h cycle=%0d", oHI, oLO, cyc);
          end
        end
        if (iStart && !oStall && !iFlush && (iFunc == 6'd16 || iFunc == 6'd18)) begin
          if (res_q.size() == 0) begin
            chk("unexpected_mf", 64'd1, 64'd0);
          end else begin
            r = res_q.pop_front();
            chk("mf_result", 64'(oResult), 64'(r));
          end
        end
      end
    end
  end

  initial begin
    int c0, c1;
    logic [5:0] funcs [8];
    logic [5:0] f;
    logic [31:0] a, b;
    funcs = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd18, 6'd17, 6'd19};

    // Reset state
    iFunc = 6'd16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(oStall), 0);
    chk("rst_busy", 64'(oBusy), 0);
    chk("rst_done", 64'(oDone), 0);
    chk("rst_hi", 64'(oHI), 0);
    chk("rst_lo", 64'(oLO), 0);
    chk("rst_result", 64'(oResult), 0);
    rst_n = 1'b1;

    // Reset in the middle of CALC discards the operation.
    run_op(6'd17, 32'hAAAA_0000, 0);
    issue(6'd24, 5, 6, 1, c0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_hi = '0; model_lo = '0;
    #1;
    chk("midrst_busy", 64'(oBusy), 0);
    chk("midrst_hi", 64'(oHI), 0);
    chk("midrst_lo", 64'(oLO), 0);
    repeat (40) @(negedge clk);

    // Directed cases
    run_op(6'd24, 7, 32'hFFFF_FFFD);
    run_op(6'd27, 100, 7);
    run_op(6'd26, 32'hFFFF_FFF9, 2);
    run_op(6'd26, 42, 0);
    run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(6'd24, 32'h8000_0000, 32'h8000_0000);
    run_op(6'd18, 0, 0);
    run_op(6'd16, 0, 0);

    // mfhi arrives while a mult is running and is accepted in the DONE cycle.
    issue(6'd24, 7, 32'hFFFF_FFFD, 0, c0);
    repeat (3) @(posedge clk);
    issue(6'd16, 0, 0, 0, c1);
`ifdef MULDIV_EARLY_TERM_EN
    chk("mfhi_accept_le_34", 64'(c1 - c0 <= 34), 1);
`else
    chk("mfhi_accept_cycle", 64'(c1 - c0), 34);
`endif

    // A flush mid-divide leaves HI/LO untouched and produces no oDone.
    run_op(6'd17, 32'h1234, 0);
    issue(6'd27, 100, 7, 1, c0);
    @(negedge clk);
    repeat (9) @(negedge clk);
    iFlush = 1'b1;
    @(negedge clk);
    iFlush = 1'b0;
    #1;
    chk("flush_busy", 64'(oBusy), 0);
    chk("flush_hi", 64'(oHI), 64'h1234);
    chk("flush_done", 64'(oDone), 0);

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      f = funcs[$urandom_range(0, 7)];
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = a & 32'hFF; b = b & 32'hF; end
        2: b = b | 32'h8000_0000;
        default: ;
      endcase
      run_op(f, a, b);
    end

    repeat (5) @(negedge clk);
    chk("done_q_empty", 64'(done_q.size()), 0);
    chk("res_q_empty", 64'(res_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
